ct_f_spsram_lane_param: RTL and testbench
=========================================

Name: ct_f_spsram_lane_param

Overview:
- Parametrised single-port synchronous SRAM wrapper; successor to the fixed 4096x32, four-byte-lane FPGA SRAM macros used in the L1/L2 data and tag arrays.
- Generalises depth, width and write-lane granularity.
- Adds three features the fixed macros lack: optional output pipeline register, read-valid strobe, and a hardware initialisation sequencer that clears the array after reset.
- Port protocol (active-low CEN/GWEN/WEN, per-lane mask sampled at lane MSB) matches existing callers so it drops in.

Parameters:
- ADDR_WIDTH, 12, address bits; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, data bits; must be a multiple of LANE_WIDTH (elaboration error otherwise).
- LANE_WIDTH, 8, bits per independently writable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- OUT_REG, 0, 1 adds one output pipeline stage (read latency 2 instead of 1).
- INIT_ON_RESET, 1, 1 runs the clear sequence after every reset deassertion.
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every entry during the clear sequence.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  reset, asynchronous assert, active-high.
- A  in  ADDR_WIDTH  access address.
- CEN  in  1  chip enable, active-low.
- GWEN  in  1  global write enable, active-low; 1 = read.
- WEN  in  DATA_WIDTH  per-bit write mask, active-low; only bit i*LANE_WIDTH+LANE_WIDTH-1 of each lane is used.
- D  in  DATA_WIDTH  write data.
- Q  out  DATA_WIDTH  read data.
- RD_VLD  out  1  one-cycle pulse: Q carries data from an accepted read.
- INIT_BUSY  out  1  clear sequence in progress; all accesses are ignored.

Behaviour:
- Reset values:
  - Q=0, RD_VLD=0.
  - Address-holding register = 0; init counter = 0.
  - INIT_BUSY = INIT_ON_RESET.
  - FSM enters CLEAR if INIT_ON_RESET=1, else READY.
  - Array contents are not reset.
- FSM CLEAR:
  - Each cycle writes INIT_VALUE to all lanes at counter, then counter increments.
  - Moves to READY after writing DEPTH-1, so INIT_BUSY is high for exactly DEPTH cycles after the first rising edge with RST low.
  - Counter wraps to 0 on exit.
- FSM READY: terminal state until the next RST.
- Reset mid-CLEAR: counter returns to 0 and the sequence restarts from entry 0.
- Accepted access: READY and CEN=0. In CLEAR, CEN/GWEN/WEN/A/D are ignored and no RD_VLD is produced.
- Write (accepted, GWEN=0):
  - Lane i written with D lane i when WEN[i*LANE_WIDTH+LANE_WIDTH-1]=0; other lanes unchanged.
  - All-lanes-masked write is a no-op.
  - No RD_VLD on a write.
- Read (accepted, GWEN=1), read-first semantics:
  - OUT_REG=0: Q = mem[A] sampled at edge N, visible after edge N; RD_VLD high for that one cycle.
  - OUT_REG=1: Q and RD_VLD appear one cycle later.
- Q on non-read cycles: holds its last value when CEN=1, on writes, and during CLEAR. Never shows write data.
- Address holding: A is captured into the holding register on every accepted access. The array address is the holding register when CEN=1, so idle cycles keep a stable macro address.
- Back-to-back:
  - A read every cycle gives one RD_VLD per cycle with no bubbles.
  - A read of address X in the cycle after a write to X returns the new data.
- Width rules: addresses are unsigned with no wrap checking; every A in 0..DEPTH-1 is legal.

Test Plan:
- ADDR_WIDTH=4, INIT_ON_RESET=1, INIT_VALUE=32'hA5A5A5A5: release RST -> INIT_BUSY high exactly 16 cycles. Then reading 0,7,15 returns 32'hA5A5A5A5 with RD_VLD one cycle after each read.
- Write A=3, D=32'h11223344, WEN=32'h00FF00FF (lanes 1,3 written) over 0xA5A5A5A5; then read 3 -> Q=32'h11A533A5, RD_VLD=1 at latency 1.
- OUT_REG=1: reads of 1,2,3 on consecutive cycles -> Q values 2,3,4 cycles after first read; RD_VLD high three consecutive cycles.
- Assert RST at counter=8 during CLEAR, release -> INIT_BUSY high 16 more cycles; a write issued during CLEAR is dropped (read afterwards returns INIT_VALUE).
- Read A=5 then CEN=1 for 4 cycles with A toggling -> Q stable, RD_VLD=0. Write 5 with D=0xDEADBEEF then read 5 next cycle -> Q=0xDEADBEEF.
- DATA_WIDTH=64, LANE_WIDTH=16, INIT_ON_RESET=0 -> INIT_BUSY=0 after reset. Write with only lane 2 enabled, then read -> only bits 47:32 changed.

Source files
------------

// File: rtl/ct_f_spsram_lane_param.sv
// Single-port synchronous SRAM wrapper with lane-masked writes, optional
// output register, read-valid strobe and a post-reset array clear sequencer.
module ct_f_spsram_lane_param #(
    parameter int                    ADDR_WIDTH    = 12,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    LANE_WIDTH    = 8,
    parameter bit                    OUT_REG       = 1'b0,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  RD_VLD,
    output logic                  INIT_BUSY
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

    if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
    end

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    busy;

    logic                    clearing;
    logic                    accept;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   arr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [NUM_LANES-1:0]    lane_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_vld;

    // Only the MSB of each lane's mask is meaningful.
    logic                    unused_wen;
    assign unused_wen = ^WEN;

    assign clearing = (state == ST_CLEAR);
    assign accept   = (state == ST_READY) && !CEN;
    assign rd_en    = accept && GWEN;
    assign wr_data  = clearing ? INIT_VALUE : D;

    // Idle cycles present the last accepted address to the array.
    always_comb begin
        arr_addr = addr_q;
        if (clearing) begin
            arr_addr = cnt;
        end else if (!CEN) begin
            arr_addr = A;
        end
    end

    always_comb begin
        lane_we = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_we[i] = clearing ||
                         (accept && !GWEN &&
                          !WEN[i*LANE_WIDTH + LANE_WIDTH - 1]);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= INIT_ON_RESET ? ST_CLEAR : ST_READY;
            cnt   <= '0;
            busy  <= INIT_ON_RESET;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state <= ST_READY;
                        busy  <= 1'b0;
                    end
                end
                ST_READY: begin
                    state <= ST_READY;
                end
                default: begin
                    state <= ST_READY;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= A;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_we[i]) begin
                mem[arr_addr][i*LANE_WIDTH +: LANE_WIDTH] <=
                    wr_data[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // Read-first: the non-blocking write above lands after this sample.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_data <= mem[arr_addr];
            end
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q_pipe;
        logic                  vld_pipe;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                q_pipe   <= '0;
                vld_pipe <= 1'b0;
            end else begin
                vld_pipe <= rd_vld;
                if (rd_vld) begin
                    q_pipe <= rd_data;
                end
            end
        end

        assign Q      = q_pipe;
        assign RD_VLD = vld_pipe;
    end else begin : g_no_out_reg
        assign Q      = rd_data;
        assign RD_VLD = rd_vld;
    end

    assign INIT_BUSY = busy;

endmodule

// File: tb/tb_ct_f_spsram_lane_param.sv
// Directed bench: latency-1 and latency-2 32-bit instances plus a 64-bit
// 16-bit-lane instance without the clear sequence.
module tb_ct_f_spsram_lane_param;

    logic        CLK;
    logic        RST;
    logic [3:0]  A;
    logic        CEN;
    logic        GWEN;
    logic [31:0] WEN;
    logic [31:0] D;
    logic [31:0] q0, q1;
    logic        vld0, vld1, busy0, busy1;

    logic [3:0]  a2;
    logic        cen2, gwen2;
    logic [63:0] wen2, d2, q2;
    logic        vld2, busy2;

    int vecs = 0;
    int errs = 0;
    int n;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    ct_f_spsram_lane_param #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .LANE_WIDTH(8),
        .OUT_REG(1'b0), .INIT_ON_RESET(1'b1), .INIT_VALUE(IV)
    ) u0 (
        .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN),
        .WEN(WEN), .D(D), .Q(q0), .RD_VLD(vld0), .INIT_BUSY(busy0)
    );

    ct_f_spsram_lane_param #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .LANE_WIDTH(8),
        .OUT_REG(1'b1), .INIT_ON_RESET(1'b1), .INIT_VALUE(IV)
    ) u1 (
        .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN),
        .WEN(WEN), .D(D), .Q(q1), .RD_VLD(vld1), .INIT_BUSY(busy1)
    );

    ct_f_spsram_lane_param #(
        .ADDR_WIDTH(4), .DATA_WIDTH(64), .LANE_WIDTH(16),
        .OUT_REG(1'b0), .INIT_ON_RESET(1'b0), .INIT_VALUE(64'h0)
    ) u2 (
        .CLK(CLK), .RST(RST), .A(a2), .CEN(cen2), .GWEN(gwen2),
        .WEN(wen2), .D(d2), .Q(q2), .RD_VLD(vld2), .INIT_BUSY(busy2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = '1;
    endtask

    task automatic rd(input logic [3:0] a);
        CEN  = 1'b0;
        GWEN = 1'b1;
        WEN  = '1;
        A    = a;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic [31:0] w);
        CEN  = 1'b0;
        GWEN = 1'b0;
        WEN  = w;
        A    = a;
        D    = d;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        A = '0;
        D = '0;
        a2 = '0;
        cen2 = 1'b1;
        gwen2 = 1'b1;
        wen2 = '1;
        d2 = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_q0", q0, 0);
        chk("rst_vld0", vld0, 0);
        chk("rst_q1", q1, 0);
        chk("rst_busy0", busy0, 1);
        chk("rst_busy2", busy2, 0);

        // Clear sequence length
        RST = 1'b0;
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            cyc();
        end
        chk("clear_len", n, 16);
        chk("clear_done_u1", busy1, 0);

        // Reads after clear
        rd(4'd0);
        cyc();
        chk("rd0_q0", q0, IV);
        chk("rd0_vld0", vld0, 1);
        chk("rd0_vld1_early", vld1, 0);
        rd(4'd7);
        cyc();
        chk("rd7_q0", q0, IV);
        chk("rd7_vld0", vld0, 1);
        chk("rd0_q1", q1, IV);
        chk("rd0_vld1", vld1, 1);
        rd(4'd15);
        cyc();
        chk("rd15_q0", q0, IV);
        chk("rd15_vld0", vld0, 1);
        idle();
        cyc();
        chk("idle_vld0", vld0, 0);
        chk("rd15_vld1", vld1, 1);
        cyc();
        chk("idle_vld1", vld1, 0);

        // Lane-masked write, lanes 1 and 3
        wr(4'd3, 32'h11223344, 32'h00FF00FF);
        cyc();
        chk("wr_no_vld", vld0, 0);
        chk("wr_q_hold", q0, IV);
        rd(4'd3);
        cyc();
        chk("lane_q0", q0, 32'h11A533A5);
        chk("lane_vld0", vld0, 1);
        idle();
        cyc();
        chk("lane_q1", q1, 32'h11A533A5);

        // Back-to-back reads through the output register
        wr(4'd1, 32'h11110001, 32'h0);
        cyc();
        wr(4'd2, 32'h11110002, 32'h0);
        cyc();
        wr(4'd3, 32'h11110003, 32'h0);
        cyc();
        idle();
        cyc();
        rd(4'd1);
        cyc();
        chk("b2b_vld1_0", vld1, 0);
        chk("b2b_q0_1", q0, 32'h11110001);
        rd(4'd2);
        cyc();
        chk("b2b_q1_1", q1, 32'h11110001);
        chk("b2b_vld1_1", vld1, 1);
        rd(4'd3);
        cyc();
        chk("b2b_q1_2", q1, 32'h11110002);
        chk("b2b_vld1_2", vld1, 1);
        idle();
        cyc();
        chk("b2b_q1_3", q1, 32'h11110003);
        chk("b2b_vld1_3", vld1, 1);
        cyc();
        chk("b2b_vld1_end", vld1, 0);
        chk("b2b_q1_hold", q1, 32'h11110003);

        // Idle cycles hold Q
        rd(4'd5);
        cyc();
        chk("rd5_q0", q0, IV);
        chk("rd5_vld0", vld0, 1);
        for (int i = 0; i < 4; i++) begin
            CEN  = 1'b1;
            GWEN = i[0];
            A    = i[0] ? 4'hA : 4'h5;
            D    = $urandom;
            cyc();
            chk("hold_q0", q0, IV);
            chk("hold_vld0", vld0, 0);
        end
        wr(4'd5, 32'hDEADBEEF, 32'h0);
        cyc();
        rd(4'd5);
        cyc();
        chk("raw_q0", q0, 32'hDEADBEEF);
        chk("raw_vld0", vld0, 1);
        idle();
        cyc();

        // Reset in the middle of the clear sequence
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        repeat (8) cyc();
        RST = 1'b1;
        cyc();
        chk("midrst_busy", busy0, 1);
        chk("midrst_q0", q0, 0);
        RST = 1'b0;
        n = 0;
        while (busy0 && n < 40) begin
            if (n == 5) wr(4'd2, 32'h12345678, 32'h0);
            else if (n == 8) rd(4'd3);
            else idle();
            n++;
            cyc();
            if (n == 9) chk("clear_no_vld", vld0, 0);
        end
        chk("clear_len2", n, 16);
        chk("clear_q_hold", q0, 0);
        rd(4'd2);
        cyc();
        chk("dropped_wr", q0, IV);
        rd(4'd5);
        cyc();
        chk("recleared5", q0, IV);
        idle();
        cyc();

        // Wide instance, only lane 2 enabled
        a2 = 4'd4;
        cen2 = 1'b0;
        gwen2 = 1'b0;
        wen2 = 64'h0;
        d2 = 64'h0123456789ABCDEF;
        cyc();
        d2 = '1;
        wen2 = 64'h80007FFF80008000;
        cyc();
        gwen2 = 1'b1;
        cyc();
        chk("wide_q2", q2, 64'h0123FFFF89ABCDEF);
        chk("wide_vld2", vld2, 1);
        cen2 = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
